// File: rtl/mtl_vid_pkg.sv
// rtl/mtl_vid_pkg.sv - state type, raster total helpers and colour-bar table for mtl_vid_stream_out
package mtl_vid_pkg;

    typedef enum logic [1:0] {
        ALIGN      = 2'd0,
        WAIT_FRAME = 2'd1,
        RUN        = 2'd2
    } vid_state_t;

    function automatic int h_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int v_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    // {R,G,B} channel enables, bar 0 at the left edge
    function automatic logic [2:0] bar_rgb(input logic [2:0] idx);
        logic [2:0] rgb;
        case (idx)
            3'd0:    rgb = 3'b111;
            3'd1:    rgb = 3'b110;
            3'd2:    rgb = 3'b011;
            3'd3:    rgb = 3'b010;
            3'd4:    rgb = 3'b101;
            3'd5:    rgb = 3'b100;
            3'd6:    rgb = 3'b001;
            default: rgb = 3'b000;
        endcase
        return rgb;
    endfunction

endpackage

// File: rtl/mtl_vid_timing_cnt.sv
// rtl/mtl_vid_timing_cnt.sv - free-running h/v raster counters with active, blank and sync decode
module mtl_vid_timing_cnt
    import mtl_vid_pkg::*;
#(
    parameter int H_ACTIVE = 800,
    parameter int H_FP     = 210,
    parameter int H_SYNC   = 1,
    parameter int H_BP     = 45,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 22,
    parameter int V_SYNC   = 1,
    parameter int V_BP     = 22,
    localparam int HW = $clog2(h_total(H_ACTIVE, H_FP, H_SYNC, H_BP)),
    localparam int VW = $clog2(v_total(V_ACTIVE, V_FP, V_SYNC, V_BP))
) (
    input  logic          clk,
    input  logic          reset,
    output logic [HW-1:0] h_cnt,
    output logic [VW-1:0] v_cnt,
    output logic          active,
    output logic          hblank,
    output logic          vblank,
    output logic          hsync,
    output logic          vsync,
    output logic          frame_last
);

    localparam int H_TOT = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOT = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOT - 1);
    localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_FIRST = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_LAST  = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOT - 1);
    localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_FIRST = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_LAST  = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic h_last;
    logic v_last;

    assign h_last = (h_cnt == H_LAST);
    assign v_last = (v_cnt == V_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_last) begin
            h_cnt <= '0;
            v_cnt <= v_last ? '0 : v_cnt + VW'(1);
        end else begin
            h_cnt <= h_cnt + HW'(1);
        end
    end

    // Axis order is active, front porch, sync, back porch
    assign hblank     = (h_cnt >= H_ACT);
    assign vblank     = (v_cnt >= V_ACT);
    assign active     = !hblank && !vblank;
    assign hsync      = (h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST);
    assign vsync      = (v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST);
    assign frame_last = h_last && v_last;

endmodule

// File: rtl/mtl_vid_stream_out.sv
// rtl/mtl_vid_stream_out.sv - clocked-video output with SOP alignment, underflow recovery and MTL_VID_TESTPAT_EN colour bars
module mtl_vid_stream_out
    import mtl_vid_pkg::*;
#(
    parameter int DATA_W   = 24,
    parameter int H_ACTIVE = 800,
    parameter int H_FP     = 210,
    parameter int H_SYNC   = 1,
    parameter int H_BP     = 45,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 22,
    parameter int V_SYNC   = 1,
    parameter int V_BP     = 22,
    parameter int SYNC_POL = 0
) (
    input  logic              clk,
    input  logic              reset,
`ifdef MTL_VID_TESTPAT_EN
    input  logic              pattern_sel,
`endif
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              in_sop,
    output logic              in_ready,
    output logic [DATA_W-1:0] vid_data,
    output logic              vid_datavalid,
    output logic              vid_h_sync,
    output logic              vid_v_sync,
    output logic              vid_h,
    output logic              vid_v,
    output logic              vid_f,
    output logic              underflow
);

    localparam int   HW       = $clog2(h_total(H_ACTIVE, H_FP, H_SYNC, H_BP));
    localparam int   VW       = $clog2(v_total(V_ACTIVE, V_FP, V_SYNC, V_BP));
    localparam logic SYNC_ACT = (SYNC_POL != 0);

    logic [HW-1:0]     h_cnt;
    logic [VW-1:0]     v_cnt;
    logic              active;
    logic              hblank;
    logic              vblank;
    logic              hsync;
    logic              vsync;
    logic              frame_last;
    logic              at_origin;

    vid_state_t        state;
    vid_state_t        state_nxt;
    logic              underflow_nxt;
    logic              ready_c;
    logic              dv_nxt;
    logic [DATA_W-1:0] data_nxt;

    mtl_vid_timing_cnt #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .clk        (clk),
        .reset      (reset),
        .h_cnt      (h_cnt),
        .v_cnt      (v_cnt),
        .active     (active),
        .hblank     (hblank),
        .vblank     (vblank),
        .hsync      (hsync),
        .vsync      (vsync),
        .frame_last (frame_last)
    );

    assign at_origin = (h_cnt == '0) && (v_cnt == '0);

`ifdef MTL_VID_TESTPAT_EN
    localparam int CW = DATA_W / 3;

    logic [2:0]        bar_idx;
    logic [2:0]        rgb;
    logic [DATA_W-1:0] bar_data;

    assign bar_idx  = 3'((int'(h_cnt) * 8) / H_ACTIVE);
    assign rgb      = bar_rgb(bar_idx);
    assign bar_data = DATA_W'({{CW{rgb[2]}}, {CW{rgb[1]}}, {CW{rgb[0]}}});
`endif

    always_comb begin
        state_nxt     = state;
        underflow_nxt = underflow;
        ready_c       = 1'b0;
        dv_nxt        = 1'b0;
        data_nxt      = '0;
        case (state)
            ALIGN: begin
                // The SOP beat is left on the bus so it can be taken at the next (0,0)
                ready_c = 1'b1;
                if (in_valid && in_sop) begin
                    ready_c   = 1'b0;
                    state_nxt = WAIT_FRAME;
                end
            end
            WAIT_FRAME: begin
                if (frame_last) begin
                    state_nxt     = RUN;
                    underflow_nxt = 1'b0;
                end
            end
            RUN: begin
                if (active) begin
                    ready_c = 1'b1;
                    if (!in_valid) begin
                        underflow_nxt = 1'b1;
                        state_nxt     = ALIGN;
                    end else if (in_sop && !at_origin) begin
                        ready_c       = 1'b0;
                        underflow_nxt = 1'b1;
                        state_nxt     = WAIT_FRAME;
                    end else if (!in_sop && at_origin) begin
                        underflow_nxt = 1'b1;
                        state_nxt     = ALIGN;
                    end else begin
                        dv_nxt   = 1'b1;
                        data_nxt = in_data;
                    end
                end
            end
            default: state_nxt = ALIGN;
        endcase
`ifdef MTL_VID_TESTPAT_EN
        if (pattern_sel) begin
            ready_c       = 1'b1;
            state_nxt     = ALIGN;
            underflow_nxt = 1'b0;
            dv_nxt        = active;
            data_nxt      = active ? bar_data : '0;
        end
`endif
    end

    assign in_ready = ready_c && !reset;
    assign vid_f    = 1'b0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ALIGN;
            underflow     <= 1'b0;
            vid_data      <= '0;
            vid_datavalid <= 1'b0;
            vid_h_sync    <= !SYNC_ACT;
            vid_v_sync    <= !SYNC_ACT;
            vid_h         <= 1'b0;
            vid_v         <= 1'b0;
        end else begin
            state         <= state_nxt;
            underflow     <= underflow_nxt;
            vid_data      <= data_nxt;
            vid_datavalid <= dv_nxt;
            vid_h_sync    <= hsync ? SYNC_ACT : !SYNC_ACT;
            vid_v_sync    <= vsync ? SYNC_ACT : !SYNC_ACT;
            vid_h         <= hblank;
            vid_v         <= vblank;
        end
    end

endmodule
